// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared encodings and helpers for the load/store unit
package mem_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Byte-lane masks written as {_0,_1,_2,_3}; bit 0 is the least-significant lane
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = MASK_B;
            SIZE_H:  size_mask = MASK_H;
            default: size_mask = MASK_W;
        endcase
    endfunction

    // Size 3 is handled as a word, so it shares the word alignment rule
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  is_misaligned = 1'b0;
            SIZE_H:  is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// rtl/mem_lsu_ext.sv - load data extractor with zero/sign extension
module mem_lsu_ext
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            size,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] result
);

    // Requested bytes arrive right-aligned; keep the low bytes and extend above them
    always_comb begin
        result = data;
        case (size)
            SIZE_B:  result = {{(DATA_WIDTH-8){is_signed & data[7]}}, data[7:0]};
            SIZE_H:  result = {{(DATA_WIDTH-16){is_signed & data[15]}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-outstanding load/store unit driving the data-memory port
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic                  iReqWr,
    input  logic [ADDR_WIDTH-1:0] iReqAddr,
    input  logic [DATA_WIDTH-1:0] iReqData,
    input  logic [1:0]            iReqSize,
    input  logic                  iReqSigned,
    output logic                  oRespValid,
    input  logic                  iRespReady,
    output logic [DATA_WIDTH-1:0] oRespData,
    output logic                  oRespErr,
    output logic                  pMemData_pRd_bEn,
    output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
    input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
    output logic                  pMemData_pWr_bEn,
    output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
    output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
    output logic                  pMemData_pWr_bMask_0,
    output logic                  pMemData_pWr_bMask_1,
    output logic                  pMemData_pWr_bMask_2,
    output logic                  pMemData_pWr_bMask_3
);

    state_t                state;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [3:0]            mask_q;
    logic [3:0]            req_mask;
    logic [DATA_WIDTH-1:0] lane_bits;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] ext_result;

    assign req_mask   = size_mask(iReqSize);
    assign misaligned = is_misaligned(iReqSize, iReqAddr[1:0]);

    // Expand the byte mask into a bit mask so unused store lanes go out as zero
    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            lane_bits[8*i +: 8] = {8{req_mask[i]}};
        end
    end

    mem_lsu_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .data      (pMemData_pRd_bData),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (ext_result)
    );

    // Handshake and enables decode straight from the state so reset drops them at once
    always_comb begin
        oReqReady        = (state == ST_IDLE) && !iReset;
        oRespValid       = (state == ST_RESP);
        pMemData_pRd_bEn = (state == ST_ISSUE) && !wr_q;
        pMemData_pWr_bEn = (state == ST_ISSUE) && wr_q;
    end

    assign pMemData_pWr_bMask_0 = mask_q[3];
    assign pMemData_pWr_bMask_1 = mask_q[2];
    assign pMemData_pWr_bMask_2 = mask_q[1];
    assign pMemData_pWr_bMask_3 = mask_q[0];

    // Request FSM; port address/data/mask registers load at accept and hold afterwards
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state              <= ST_IDLE;
            wr_q               <= 1'b0;
            size_q             <= SIZE_B;
            signed_q           <= 1'b0;
            mask_q             <= 4'b0000;
            oRespData          <= '0;
            oRespErr           <= 1'b0;
            pMemData_pRd_bAddr <= '0;
            pMemData_pWr_bAddr <= '0;
            pMemData_pWr_bData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iReqValid) begin
                        wr_q      <= iReqWr;
                        size_q    <= iReqSize;
                        signed_q  <= iReqSigned;
                        oRespData <= '0;
                        oRespErr  <= misaligned;
                        if (misaligned) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                            if (iReqWr) begin
                                pMemData_pWr_bAddr <= iReqAddr;
                                pMemData_pWr_bData <= iReqData & lane_bits;
                                mask_q             <= req_mask;
                            end else begin
                                pMemData_pRd_bAddr <= iReqAddr;
                            end
                        end
                    end
                end
                ST_ISSUE: state <= wr_q ? ST_RESP : ST_DATA;
                ST_DATA: begin
                    oRespData <= ext_result;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (iRespReady) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard testbench for mem_lsu
module tb_mem_lsu;

    logic        iClock;
    logic        iReset;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWr;
    logic [31:0] iReqAddr;
    logic [31:0] iReqData;
    logic [1:0]  iReqSize;
    logic        iReqSigned;
    logic        oRespValid;
    logic        iRespReady;
    logic [31:0] oRespData;
    logic        oRespErr;
    logic        pMemData_pRd_bEn;
    logic [31:0] pMemData_pRd_bAddr;
    logic [31:0] pMemData_pRd_bData;
    logic        pMemData_pWr_bEn;
    logic [31:0] pMemData_pWr_bAddr;
    logic [31:0] pMemData_pWr_bData;
    logic        pMemData_pWr_bMask_0;
    logic        pMemData_pWr_bMask_1;
    logic        pMemData_pWr_bMask_2;
    logic        pMemData_pWr_bMask_3;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem_ret = 32'h0;

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iClock               (iClock),
        .iReset               (iReset),
        .iReqValid            (iReqValid),
        .oReqReady            (oReqReady),
        .iReqWr               (iReqWr),
        .iReqAddr             (iReqAddr),
        .iReqData             (iReqData),
        .iReqSize             (iReqSize),
        .iReqSigned           (iReqSigned),
        .oRespValid           (oRespValid),
        .iRespReady           (iRespReady),
        .oRespData            (oRespData),
        .oRespErr             (oRespErr),
        .pMemData_pRd_bEn     (pMemData_pRd_bEn),
        .pMemData_pRd_bAddr   (pMemData_pRd_bAddr),
        .pMemData_pRd_bData   (pMemData_pRd_bData),
        .pMemData_pWr_bEn     (pMemData_pWr_bEn),
        .pMemData_pWr_bAddr   (pMemData_pWr_bAddr),
        .pMemData_pWr_bData   (pMemData_pWr_bData),
        .pMemData_pWr_bMask_0 (pMemData_pWr_bMask_0),
        .pMemData_pWr_bMask_1 (pMemData_pWr_bMask_1),
        .pMemData_pWr_bMask_2 (pMemData_pWr_bMask_2),
        .pMemData_pWr_bMask_3 (pMemData_pWr_bMask_3)
    );

    wire [136:0] all_outs = {oReqReady, oRespValid, oRespErr, oRespData,
                             pMemData_pRd_bEn, pMemData_pRd_bAddr,
                             pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
                             pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
                             pMemData_pWr_bMask_2, pMemData_pWr_bMask_3};

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Memory model: data valid the cycle after the read enable, junk otherwise
    always @(posedge iClock) begin
        pMemData_pRd_bData <= pMemData_pRd_bEn ? mem_ret : 32'h5A5A5A5A;
    end

    // Scoreboard: compare each response at its handshake
    always @(negedge iClock) begin
        if (!iReset && oRespValid && iRespReady) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: data=%h err=%b with empty scoreboard", oRespData, oRespErr);
            end else begin
                e = sb.pop_front();
                if (oRespData !== e.data || oRespErr !== e.err) begin
                    n_fail++;
                    $display("FAIL resp: got data=%h err=%b, expected data=%h err=%b",
                             oRespData, oRespErr, e.data, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Present a request for one edge and queue its expected response
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic sgn,
                        input logic [31:0] exp_data, input logic exp_err);
        iReqValid  = 1'b1;
        iReqWr     = wr;
        iReqAddr   = addr;
        iReqData   = data;
        iReqSize   = size;
        iReqSigned = sgn;
        n_checks++;
        if (oReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready: got %b, expected 1", oReqReady);
        end
        sb.push_back('{exp_data, exp_err});
        @(posedge iClock); #1;
        iReqValid = 1'b0;
    endtask

    // Follow cycles T+1.. until the response appears, recording port activity
    task automatic watch(output int lat, output int n_rd, output int n_wr,
                         output logic [3:0] mask, output logic [31:0] wdata,
                         output logic [31:0] waddr, output logic [31:0] raddr);
        lat = 0; n_rd = 0; n_wr = 0; mask = 4'h0; wdata = 32'h0; waddr = 32'h0; raddr = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            if (pMemData_pRd_bEn) begin
                n_rd++;
                raddr = pMemData_pRd_bAddr;
            end
            if (pMemData_pWr_bEn) begin
                n_wr++;
                mask  = {pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
                         pMemData_pWr_bMask_2, pMemData_pWr_bMask_3};
                wdata = pMemData_pWr_bData;
                waddr = pMemData_pWr_bAddr;
            end
            if (oRespValid) begin
                lat = k;
                break;
            end
            @(posedge iClock); #1;
        end
    endtask

    task automatic test_reset;
        @(posedge iClock); #1;
        n_checks++;
        if (all_outs !== 137'h0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h, expected all zero", all_outs);
        end
        @(negedge iClock);
        iReset = 1'b0;
        @(posedge iClock); #1;
        n_checks++;
        if (oReqReady !== 1'b1 || oRespValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ready=%b valid=%b, expected 1/0", oReqReady, oRespValid);
        end
    endtask

    task automatic test_store_byte;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        send(1'b1, 32'h80000003, 32'h123456AB, 2'd0, 1'b0, 32'h0, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 2 || n_wr !== 1 || n_rd !== 0) begin
            n_fail++;
            $display("FAIL st_b_timing: lat=%0d wr=%0d rd=%0d, expected 2/1/0", lat, n_wr, n_rd);
        end
        n_checks++;
        if (mask !== 4'b0001 || wdata !== 32'h000000AB || waddr !== 32'h80000003) begin
            n_fail++;
            $display("FAIL st_b_port: mask=%b data=%h addr=%h, expected 0001/000000ab/80000003",
                     mask, wdata, waddr);
        end
        @(posedge iClock); #1;
        n_checks++;
        if (oRespValid !== 1'b0 || oReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL st_b_idle: valid=%b ready=%b, expected 0/1", oRespValid, oReqReady);
        end
    endtask

    task automatic test_load_byte;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        mem_ret = 32'h000000AB;
        send(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 32'hFFFFFFAB, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 3 || n_rd !== 1 || n_wr !== 0 || raddr !== 32'h80000003) begin
            n_fail++;
            $display("FAIL ld_b_timing: lat=%0d rd=%0d wr=%0d raddr=%h, expected 3/1/0/80000003",
                     lat, n_rd, n_wr, raddr);
        end
        @(posedge iClock); #1;
        send(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 32'h000000AB, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        @(posedge iClock); #1;
        mem_ret = 32'h123456AB;
        send(1'b0, 32'h80000001, 32'h0, 2'd0, 1'b0, 32'h000000AB, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        @(posedge iClock); #1;
        mem_ret = 32'hFFFFFF7F;
        send(1'b0, 32'h80000002, 32'h0, 2'd0, 1'b1, 32'h0000007F, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        @(posedge iClock); #1;
    endtask

    task automatic test_half;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        send(1'b1, 32'h80000002, 32'hFFFF8001, 2'd1, 1'b0, 32'h0, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 2 || mask !== 4'b0011 || wdata !== 32'h00008001 || waddr !== 32'h80000002) begin
            n_fail++;
            $display("FAIL st_h: lat=%0d mask=%b data=%h addr=%h, expected 2/0011/00008001/80000002",
                     lat, mask, wdata, waddr);
        end
        @(posedge iClock); #1;
        mem_ret = 32'h00008001;
        send(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b1, 32'hFFFF8001, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        @(posedge iClock); #1;
        send(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b0, 32'h00008001, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        @(posedge iClock); #1;
    endtask

    task automatic test_word;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        send(1'b1, 32'h80000004, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 2 || mask !== 4'b1111 || wdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL st_w: lat=%0d mask=%b data=%h, expected 2/1111/cafef00d", lat, mask, wdata);
        end
        @(posedge iClock); #1;
        mem_ret = 32'hCAFEF00D;
        send(1'b0, 32'h80000004, 32'h0, 2'd3, 1'b1, 32'hCAFEF00D, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 3 || n_rd !== 1) begin
            n_fail++;
            $display("FAIL ld_size3: lat=%0d rd=%0d, expected 3/1", lat, n_rd);
        end
        @(posedge iClock); #1;
    endtask

    task automatic test_misaligned;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        send(1'b0, 32'h80000001, 32'h0, 2'd1, 1'b1, 32'h0, 1'b1);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 1 || n_rd !== 0 || n_wr !== 0) begin
            n_fail++;
            $display("FAIL mis_ld_h: lat=%0d rd=%0d wr=%0d, expected 1/0/0", lat, n_rd, n_wr);
        end
        @(posedge iClock); #1;
        send(1'b1, 32'h80000002, 32'hFFFFFFFF, 2'd2, 1'b0, 32'h0, 1'b1);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 1 || n_rd !== 0 || n_wr !== 0) begin
            n_fail++;
            $display("FAIL mis_st_w: lat=%0d rd=%0d wr=%0d, expected 1/0/0", lat, n_rd, n_wr);
        end
        @(posedge iClock); #1;
        n_checks++;
        if (pMemData_pRd_bEn !== 1'b0 || pMemData_pWr_bEn !== 1'b0 || oReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_after: rd=%b wr=%b ready=%b, expected 0/0/1",
                     pMemData_pRd_bEn, pMemData_pWr_bEn, oReqReady);
        end
    endtask

    task automatic test_back_pressure;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        iRespReady = 1'b0;
        mem_ret = 32'hDEADBEEF;
        send(1'b0, 32'h80000000, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL bp_latency: lat=%0d, expected 3", lat);
        end
        iReqValid = 1'b1;
        iReqWr    = 1'b1;
        iReqAddr  = 32'h80000010;
        iReqData  = 32'h11111111;
        iReqSize  = 2'd2;
        for (int c = 0; c < 5; c++) begin
            @(posedge iClock); #1;
            n_checks++;
            if (oRespValid !== 1'b1 || oRespData !== 32'hDEADBEEF || oRespErr !== 1'b0 ||
                oReqReady !== 1'b0 || pMemData_pWr_bEn !== 1'b0 || pMemData_pRd_bEn !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h err=%b ready=%b wr=%b rd=%b",
                         c, oRespValid, oRespData, oRespErr, oReqReady,
                         pMemData_pWr_bEn, pMemData_pRd_bEn);
            end
        end
        iReqValid  = 1'b0;
        iRespReady = 1'b1;
        @(posedge iClock); #1;
        n_checks++;
        if (oRespValid !== 1'b0 || oReqReady !== 1'b1 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b pending=%0d, expected 0/1/0",
                     oRespValid, oReqReady, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int lat, n_rd, n_wr;
        logic [3:0] mask;
        logic [31:0] wdata, waddr, raddr;
        mem_ret = 32'h01020304;
        send(1'b0, 32'h80000008, 32'h0, 2'd2, 1'b0, 32'h01020304, 1'b0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== 137'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outs: got %h, expected all zero", all_outs);
        end
        sb.delete();
        @(posedge iClock); #1;
        iReset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge iClock); #1;
            n_checks++;
            if (oRespValid !== 1'b0 || oReqReady !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_quiet: cycle %0d valid=%b ready=%b, expected 0/1",
                         c, oRespValid, oReqReady);
            end
        end
        mem_ret = 32'h0BADF00D;
        send(1'b0, 32'h8000000C, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1'b0);
        watch(lat, n_rd, n_wr, mask, wdata, waddr, raddr);
        n_checks++;
        if (lat !== 3 || n_rd !== 1 || raddr !== 32'h8000000C) begin
            n_fail++;
            $display("FAIL rst_mid_reload: lat=%0d rd=%0d raddr=%h, expected 3/1/8000000c",
                     lat, n_rd, raddr);
        end
        @(posedge iClock); #1;
    endtask

    initial begin
        iReset     = 1'b1;
        iReqValid  = 1'b0;
        iReqWr     = 1'b0;
        iReqAddr   = 32'h0;
        iReqData   = 32'h0;
        iReqSize   = 2'd0;
        iReqSigned = 1'b0;
        iRespReady = 1'b1;
        test_reset;
        test_store_byte;
        test_load_byte;
        test_half;
        test_word;
        test_misaligned;
        test_back_pressure;
        test_reset_mid;
        @(posedge iClock); #1;
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses missing, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
